in_fifo_sync_param: RTL and testbench

Single-clock, parametrised successor to the fixed 10-channel input FIFO primitive model. It adds configurable channel count, input width, depth and almost-flag thresholds, plus an optional 1:2 write-side gearbox that packs two narrow input beats into one wide entry. It also provides an occupancy count and sticky overflow/underflow error flags. It sits between the input deserialisers and fabric logic wherever both sides share one clock.

---
 rtl/in_fifo_sync_param.sv | 203 ++++++++++++++++++++
 tb/tb_in_fifo_sync_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/in_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : in_fifo_sync_param
// Purpose  : Single-clock parametrised input FIFO sitting between the input
//            deserialisers and fabric logic. Optional 1:2 write-side gearbox
//            packs two narrow beats into one wide entry. Provides registered
//            status flags, an occupancy count and sticky error flags.
// Ports    : CLK        - sole clock, rising edge
//            RESET      - asynchronous active-high reset, clears all state
//            WREN / D   - write beat strobe and per-channel data
//            RDEN       - read strobe, Q updates one edge later
//            CLR_ERR    - synchronous clear of OVERFLOW / UNDERFLOW
//            Q          - per-channel entry, upper half is the later beat
//            EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL - registered status flags
//            COUNT      - entries currently stored
//            OVERFLOW, UNDERFLOW - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module in_fifo_sync_param #(
  parameter int NUM_CH             = 10,
  parameter int DIN_WIDTH          = 4,
  parameter int DEPTH              = 8,
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter     ARRAY_MODE         = "GEAR_2X"
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              WREN,
  input  logic [NUM_CH*DIN_WIDTH-1:0]       D,
  input  logic                              RDEN,
  input  logic                              CLR_ERR,
  output logic [NUM_CH*2*DIN_WIDTH-1:0]     Q,
  output logic                              EMPTY,
  output logic                              ALMOSTEMPTY,
  output logic                              FULL,
  output logic                              ALMOSTFULL,
  output logic [$clog2(DEPTH):0]            COUNT,
  output logic                              OVERFLOW,
  output logic                              UNDERFLOW
);

  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = AW + 1;
  localparam int DW         = NUM_CH * DIN_WIDTH;
  localparam int EW         = 2 * DW;
  localparam bit IS_GEAR_2X = (ARRAY_MODE == "GEAR_2X");
  localparam bit IS_GEAR_1X = (ARRAY_MODE == "GEAR_1X");

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality checks
  // --------------------------------------------------------------------------
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_err_num_ch
    $fatal(1, "Attribute Syntax Error : NUM_CH on instance %m is %0d; legal values are 1 to 16.", NUM_CH);
  end
  if (DIN_WIDTH < 1 || DIN_WIDTH > 16) begin : g_err_din_width
    $fatal(1, "Attribute Syntax Error : DIN_WIDTH on instance %m is %0d; legal values are 1 to 16.", DIN_WIDTH);
  end
  if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
    $fatal(1, "Attribute Syntax Error : DEPTH on instance %m is %0d; legal values are 4, 8, 16, 32, 64.", DEPTH);
  end
  if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH - 2) begin : g_err_ae
    $fatal(1, "Attribute Syntax Error : ALMOST_EMPTY_VALUE on instance %m is %0d; legal values are 1 to DEPTH-2.", ALMOST_EMPTY_VALUE);
  end
  if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH - 2) begin : g_err_af
    $fatal(1, "Attribute Syntax Error : ALMOST_FULL_VALUE on instance %m is %0d; legal values are 1 to DEPTH-2.", ALMOST_FULL_VALUE);
  end
  if (!IS_GEAR_2X && !IS_GEAR_1X) begin : g_err_array_mode
    $fatal(1, "Attribute Syntax Error : ARRAY_MODE on instance %m is illegal; legal values are GEAR_2X and GEAR_1X.");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          empty_q,  empty_d;
  logic          aempty_q, aempty_d;
  logic          full_q,   full_d;
  logic          afull_q,  afull_d;
  logic          ovf_q,    ovf_d;
  logic          unf_q,    unf_d;
  logic          phase_q,  phase_d;
  logic [DW-1:0] hold_q,   hold_d;
  logic [EW-1:0] q_q,      q_d;

  // Storage is not reset; Q is a separate reset register so that stale
  // storage never appears on the output until a real pop happens.
  logic [EW-1:0] mem [DEPTH];

  logic          push_req;
  logic          push_ok;
  logic          pop_ok;
  logic [EW-1:0] entry;

  // --------------------------------------------------------------------------
  // Entry packing: per channel, lower half is the earlier beat (the held one
  // in 2x mode), upper half the later beat. 1x mode zero-fills the upper half.
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    if (IS_GEAR_2X) begin : g_gear2
      assign entry[c*2*DIN_WIDTH +: 2*DIN_WIDTH] =
        {D[c*DIN_WIDTH +: DIN_WIDTH], hold_q[c*DIN_WIDTH +: DIN_WIDTH]};
    end else begin : g_gear1
      assign entry[c*2*DIN_WIDTH +: 2*DIN_WIDTH] =
        {{DIN_WIDTH{1'b0}}, D[c*DIN_WIDTH +: DIN_WIDTH]};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // In 2x mode only the second beat of a pair produces a push; the first
    // beat only loads the holding register and is never rejected.
    push_req = IS_GEAR_2X ? (WREN & phase_q) : WREN;
    // Acceptance uses the registered flags only, so a same-cycle read
    // cannot make room for a push into a full FIFO.
    push_ok  = push_req & ~full_q;
    pop_ok   = RDEN & ~empty_q;

    wr_ptr_d = push_ok ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

    // Flags are derived from the next count so they line up with COUNT.
    empty_d  = (count_d == '0);
    full_d   = (count_d == CW'(DEPTH));
    aempty_d = (count_d <= CW'(ALMOST_EMPTY_VALUE));
    afull_d  = (count_d >= CW'(DEPTH - ALMOST_FULL_VALUE));

    // CLR_ERR wins over a new error in the same cycle.
    ovf_d = CLR_ERR ? 1'b0 : (ovf_q | (push_req & full_q));
    unf_d = CLR_ERR ? 1'b0 : (unf_q | (RDEN & empty_q));

    // Phase returns to 0 after a second beat even when the pair is dropped.
    phase_d = phase_q;
    hold_d  = hold_q;
    if (IS_GEAR_2X && WREN) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hold_d = D;
      end
    end

    q_d = pop_ok ? mem[rd_ptr_q] : q_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      phase_q  <= 1'b0;
      hold_q   <= '0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      q_q      <= q_d;
    end
  end

  // Storage array write port; a push only ever lands in a free slot.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= entry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Q           = q_q;
  assign EMPTY       = empty_q;
  assign ALMOSTEMPTY = aempty_q;
  assign FULL        = full_q;
  assign ALMOSTFULL  = afull_q;
  assign COUNT       = count_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_in_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_in_fifo_sync_param
// Purpose  : Self-checking bench for in_fifo_sync_param. Instance 1 uses the
//            default GEAR_2X configuration against a queue-based model;
//            instance 2 uses a GEAR_1X 2x8-bit, depth-16 configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_in_fifo_sync_param;

  localparam int NCH = 10;
  localparam int DWC = 4;
  localparam int DEP = 8;
  localparam int AEV = 1;
  localparam int AFV = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // instance 1 (defaults)
  logic        wren = 1'b0, rden = 1'b0, clr_err = 1'b0;
  logic [39:0] din = '0;
  logic [79:0] q;
  logic        empty, aempty, full, afull, ovf, unf;
  logic [3:0]  count;

  // instance 2 (GEAR_1X)
  logic        wren2 = 1'b0, rden2 = 1'b0, clr2 = 1'b0;
  logic [15:0] din2 = '0;
  logic [31:0] q2;
  logic        empty2, aempty2, full2, afull2, ovf2, unf2;
  logic [4:0]  count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  in_fifo_sync_param u_dut (
    .CLK(clk), .RESET(rst), .WREN(wren), .D(din), .RDEN(rden), .CLR_ERR(clr_err),
    .Q(q), .EMPTY(empty), .ALMOSTEMPTY(aempty), .FULL(full), .ALMOSTFULL(afull),
    .COUNT(count), .OVERFLOW(ovf), .UNDERFLOW(unf)
  );

  in_fifo_sync_param #(
    .NUM_CH(2), .DIN_WIDTH(8), .DEPTH(16), .ALMOST_EMPTY_VALUE(2),
    .ALMOST_FULL_VALUE(1), .ARRAY_MODE("GEAR_1X")
  ) u_dut2 (
    .CLK(clk), .RESET(rst), .WREN(wren2), .D(din2), .RDEN(rden2), .CLR_ERR(clr2),
    .Q(q2), .EMPTY(empty2), .ALMOSTEMPTY(aempty2), .FULL(full2), .ALMOSTFULL(afull2),
    .COUNT(count2), .OVERFLOW(ovf2), .UNDERFLOW(unf2)
  );

  // ---------------------------------------------------------------- model
  logic [79:0] mq[$];
  logic [39:0] m_hold;
  bit          m_phase;
  logic [79:0] m_q;
  bit          m_ovf, m_unf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [79:0] pack(input logic [39:0] later, input logic [39:0] earlier);
    logic [79:0] r;
    for (int c = 0; c < NCH; c++) r[c*8 +: 8] = {later[c*4 +: 4], earlier[c*4 +: 4]};
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_hold = '0; m_phase = 0; m_q = '0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_update(input bit wr, input logic [39:0] d, input bit rd, input bit clr);
    bit was_full  = (mq.size() == DEP);
    bit was_empty = (mq.size() == 0);
    if (rd) begin
      if (!was_empty) m_q = mq.pop_front();
      else            m_unf = 1;
    end
    if (wr && m_phase) begin
      if (!was_full) mq.push_back(pack(d, m_hold));
      else           m_ovf = 1;
    end
    if (wr) begin
      if (!m_phase) m_hold = d;
      m_phase = !m_phase;
    end
    if (clr) begin m_ovf = 0; m_unf = 0; end
  endtask

  task automatic check_all();
    int n = mq.size();
    check("count",  count,  n);
    check("empty",  empty,  n == 0);
    check("full",   full,   n == DEP);
    check("aempty", aempty, n <= AEV);
    check("afull",  afull,  n >= DEP - AFV);
    check("ovf",    ovf,    m_ovf);
    check("unf",    unf,    m_unf);
    check("q",      q,      m_q);
  endtask

  // Drive one cycle, advance the model over the edge, compare after it.
  task automatic step(input bit wr, input logic [39:0] d, input bit rd, input bit clr);
    wren = wr; din = d; rden = rd; clr_err = clr;
    @(posedge clk);
    model_update(wr, d, rd, clr);
    #1;
    check_all();
    wren = 0; rden = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] v = {$urandom, $urandom};
    return v[39:0];
  endfunction

  initial begin
    logic [39:0] pat;
    model_reset();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    check_all();  // reset state

    // Basic pair write and read
    step(1, {10{4'h3}}, 0, 0);
    step(1, {10{4'hA}}, 0, 0);
    check("empty_after_pair", empty, 1'b0);
    step(0, '0, 1, 0);
    check("q_a3", q, {10{8'hA3}});
    check("empty_after_read", empty, 1'b1);

    // Fill, overflow, drain
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pat = {10{i[3:0]}};
      step(1, pat, 0, 0);
      if (i == 13) check("afull_at_7", afull, 1'b1);
    end
    check("full_at_8", full, 1'b1);
    step(1, {10{4'hF}}, 0, 0);
    step(1, {10{4'hE}}, 0, 0);
    check("ovf_set", ovf, 1'b1);
    check("count_stays_8", count, 4'd8);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    check("drain_last", q, {10{8'hFE}});
    // a fresh pair proves the dropped pair left phase at 0
    step(1, {10{4'h1}}, 0, 0);
    step(1, {10{4'h2}}, 0, 0);
    step(0, '0, 1, 0);
    check("after_ovf_pair", q, {10{8'h21}});

    // Underflow and error clear
    do_reset();
    step(0, '0, 1, 0);
    check("unf_set", unf, 1'b1);
    check("unf_q_zero", q, 80'h0);
    step(0, '0, 0, 1);
    check("unf_cleared", unf, 1'b0);
    step(0, '0, 1, 1);
    check("clr_priority", unf, 1'b0);

    // Simultaneous push and pop at COUNT=4 across pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) step(1, {10{i[3:0]}}, 0, 0);
    for (int i = 0; i < 20; i++) begin
      pat = {10{4'(i + 8)}};
      step(1, pat, i[0], 0);
      check("count_const_4", count, 4'd4);
    end

    // Asynchronous reset mid-stream after a phase-0 beat with COUNT=5
    do_reset();
    for (int i = 0; i < 10; i++) step(1, rnd40(), 0, 0);
    step(1, {10{4'h9}}, 0, 0);
    check("count_5", count, 4'd5);
    #2 rst = 1'b1;
    #1;
    check("ar_q", q, 80'h0);
    check("ar_count", count, 4'd0);
    check("ar_flags", {empty, aempty, full, afull, ovf, unf}, 6'b110000);
    model_reset();
    #1 rst = 1'b0;
    step(1, {10{4'h4}}, 0, 0);
    step(1, {10{4'h7}}, 0, 0);
    step(0, '0, 1, 0);
    check("ar_pair", q, {10{8'h74}});

    // Randomised traffic in three load profiles
    for (int seg = 0; seg < 3; seg++) begin
      int pw = (seg == 0) ? 80 : (seg == 1) ? 50 : 25;
      int pr = (seg == 0) ? 30 : (seg == 1) ? 50 : 80;
      for (int i = 0; i < 600; i++) begin
        step($urandom_range(99) < pw, rnd40(), $urandom_range(99) < pr,
             $urandom_range(99) < 3);
      end
    end

    // GEAR_1X instance
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      wren2 = 1'b1; din2 = {2{4'(i), 4'(i)}};
      @(posedge clk); #1;
      check("g1_count", count2, 5'(i));
      check("g1_aempty", aempty2, i <= 2);
    end
    wren2 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      rden2 = 1'b1;
      @(posedge clk); #1;
      check("g1_q", q2, {2{8'h00, 4'(i), 4'(i)}});
    end
    rden2 = 1'b0;
    check("g1_empty", empty2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
